mesi_isc_breq_rr_arb: RTL and testbench
=======================================

// Module: mesi_isc_breq_rr_arb
// PURPOSE
// - Round-robin drain controller for the four per-CPU mesi_isc_basic_fifo breq queues.
// - Pops one bus request at a time from a non-empty CPU queue and pushes it into the
//   shared broadcast FIFO, tagging it with the CPU id and a sequence broad_id.
// - Sits between the breq FIFOs and the broadcast FIFO in mesi_isc. It is the only
//   writer of the broadcast FIFO.
// PARAMETERS
// - ADDR_WIDTH        32  address bits per request
// - BROAD_TYPE_WIDTH   2  request type bits; head data is {type, addr}
// - BROAD_ID_WIDTH     7  sequence-id counter width
// PORTS
// - clk                 in   1      clock; all logic on posedge
// - rst                 in   1      asynchronous, active-high reset
// - en_i                in   1      1 = new grants allowed; in-flight request always completes
// - fifo_empty_array_i  in   4      status_empty_o of CPU queues 3..0
// - fifo_data_array_i   in   4*(ADDR_WIDTH+BROAD_TYPE_WIDTH)  data_o of CPU queues, CPU n at slice n
// - broad_fifo_full_i   in   1      status_full_o of broadcast FIFO
// - fifo_rd_array_o     out  4      rd_i strobes to CPU queues, at most one bit set
// - broad_fifo_wr_o     out  1      wr_i strobe to broadcast FIFO
// - broad_addr_o        out  ADDR_WIDTH
// - broad_type_o        out  BROAD_TYPE_WIDTH
// - broad_cpu_id_o      out  2      source CPU of broad_* fields
// - broad_id_o          out  BROAD_ID_WIDTH  sequence id of broad_* fields
// - drop_o              out  1      1-cycle pulse: popped entry had type NOP (0) and was discarded
// BEHAVIOUR
// - Reset values: state IDLE; fifo_rd_array_o=0, broad_fifo_wr_o=0, drop_o=0.
//   broad_addr/type/cpu_id/id_o=0. Sequence counter=0. last_grant=3, so CPU0 wins first.
// - All outputs are registered and Moore-decoded from state or capture registers.
// - FSM has four states:
//   IDLE: grant when en_i & ~broad_fifo_full_i & (~fifo_empty_array_i != 0).
//         winner w = first non-empty CPU scanning last_grant+1, +2, +3, +4 (mod 4).
//         Latch w into last_grant, then go to RD. Otherwise stay in IDLE.
//   RD:   fifo_rd_array_o = 1<<w for exactly one cycle -> CAP.
//   CAP:  the queue's data_o is now valid (queue read latency is 1). Sample slice w.
//         type != 0: load broad_addr/type_o, broad_cpu_id_o=w, broad_id_o=counter;
//           go to WR.
//         type == 0: pulse drop_o next cycle, no write, counter unchanged; go to IDLE.
//   WR:   broad_fifo_wr_o=1 for one cycle; counter += 1, wrapping 127->0 -> IDLE.
// - Latency: grant cycle to broad_fifo_wr_o is 3 clocks; minimum 4 clocks per request.
// - broad_* fields hold their value outside WR, so the write data is stable while
//   wr_i is high.
// - Full handling: broad_fifo_full_i is checked only in IDLE. This block is the sole
//   writer and each transaction issues one write, so space is guaranteed at WR.
//   Full that rises in RD/CAP is impossible by construction; the bench asserts it.
// - An empty CPU queue is never read (matches the queue's read assumption).
// - A grant is never given to a queue whose empty flag is high in IDLE.
// - en_i falling mid-transaction does not abort it; the next grant waits for en_i.
// - Simultaneous requests from all CPUs are granted in strict rotation:
//   0,1,2,3,0,... from reset.
// - rst asserted mid-transaction: the popped entry is lost and state returns to reset
//   values immediately (async). This is acceptable; the cache re-requests on timeout.
// STRUCTURE
// - mesi_isc_breq_arb_pkg: state enum {IDLE,RD,CAP,WR}, BREQ_TYPE_NOP=2'd0, and a
//   breq_data_t struct {type, addr}.
// - Sub-module mesi_isc_rr_pick: combinational 4-way rotating priority encoder.
//   Inputs req[3:0] and last[1:0]; outputs gnt_vld and gnt_id[1:0].
// TESTING
// - Reset, then CPU2 queue holds {type=1, addr=32'h1000}:
//   fifo_rd_array_o=4'b0100 at cycle 1, broad_fifo_wr_o at cycle 3 with
//   addr=32'h1000, cpu_id=2, id=0.
// - All four queues non-empty, 2 entries each:
//   write order cpu_id 0,1,2,3,0,1,2,3; broad_id 0..7.
// - broad_fifo_full_i=1 with CPU1 non-empty:
//   no fifo_rd strobe while full; first rd occurs 1 cycle after full drops.
// - CPU0 head has type=0:
//   rd strobe, then drop_o pulse, no broad_fifo_wr_o; the next write carries broad_id unchanged.
// - 128 back-to-back valid requests: broad_id wraps 127->0 on the 129th.
//   Assertion: $onehot0(fifo_rd_array_o) holds throughout.
// - rst pulsed during CAP:
//   all outputs are 0 in the same cycle; the next grant after reset goes to CPU0.

Source files
------------

// File: rtl/mesi_isc_breq_arb_pkg.sv
// rtl/mesi_isc_breq_arb_pkg.sv - shared types for the breq round-robin drain controller
package mesi_isc_breq_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } state_t;

    localparam int         BREQ_ADDR_W   = 32;
    localparam int         BREQ_TYPE_W   = 2;
    localparam logic [1:0] BREQ_TYPE_NOP = 2'd0;

    // Layout of one CPU queue head: type in the upper bits, address below.
    typedef struct packed {
        logic [BREQ_TYPE_W-1:0] typ;
        logic [BREQ_ADDR_W-1:0] addr;
    } breq_data_t;

endpackage

// File: rtl/mesi_isc_rr_pick.sv
// rtl/mesi_isc_rr_pick.sv - 4-way rotating priority encoder
// The requester just after last_i has highest priority; last_i itself is lowest.
module mesi_isc_rr_pick
    import mesi_isc_breq_arb_pkg::*;
(
    input  logic [3:0] req_i,
    input  logic [1:0] last_i,
    output logic       gnt_vld_o,
    output logic [1:0] gnt_id_o
);

    logic [1:0] idx;

    // Scan from farthest to nearest so the nearest requester overwrites the rest.
    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_id_o  = 2'd0;
        idx       = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = last_i + 2'(k);
            if (req_i[idx]) begin
                gnt_vld_o = 1'b1;
                gnt_id_o  = idx;
            end
        end
    end

endmodule

// File: rtl/mesi_isc_breq_rr_arb.sv
// rtl/mesi_isc_breq_rr_arb.sv - round-robin drain of four CPU breq queues into the broadcast FIFO
// Each transaction is IDLE(grant) -> RD(pop) -> CAP(sample head) -> WR(push), all outputs registered.
module mesi_isc_breq_rr_arb
    import mesi_isc_breq_arb_pkg::*;
#(
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 7
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      en_i,
    input  logic [3:0]                                fifo_empty_array_i,
    input  logic [4*(ADDR_WIDTH+BROAD_TYPE_WIDTH)-1:0] fifo_data_array_i,
    input  logic                                      broad_fifo_full_i,
    output logic [3:0]                                fifo_rd_array_o,
    output logic                                      broad_fifo_wr_o,
    output logic [ADDR_WIDTH-1:0]                     broad_addr_o,
    output logic [BROAD_TYPE_WIDTH-1:0]               broad_type_o,
    output logic [1:0]                                broad_cpu_id_o,
    output logic [BROAD_ID_WIDTH-1:0]                 broad_id_o,
    output logic                                      drop_o
);

    localparam int DW = ADDR_WIDTH + BROAD_TYPE_WIDTH;

    state_t                      state_q, state_d;
    logic [1:0]                  last_q, last_d;
    logic [BROAD_ID_WIDTH-1:0]   cnt_q, cnt_d;
    logic [3:0]                  rd_q, rd_d;
    logic                        wr_q, wr_d;
    logic                        drop_q, drop_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [BROAD_TYPE_WIDTH-1:0] type_q, type_d;
    logic [1:0]                  cpu_q, cpu_d;
    logic [BROAD_ID_WIDTH-1:0]   id_q, id_d;

    logic                        gnt_vld;
    logic [1:0]                  gnt_id;
    logic [DW-1:0]               head;

    mesi_isc_rr_pick u_pick (
        .req_i     (~fifo_empty_array_i),
        .last_i    (last_q),
        .gnt_vld_o (gnt_vld),
        .gnt_id_o  (gnt_id)
    );

    // last_q holds the granted CPU for the whole transaction, so it selects the head slice.
    assign head = fifo_data_array_i[int'(last_q)*DW +: DW];

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rd_d    = 4'b0000;
        wr_d    = 1'b0;
        drop_d  = 1'b0;
        addr_d  = addr_q;
        type_d  = type_q;
        cpu_d   = cpu_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (en_i && !broad_fifo_full_i && gnt_vld) begin
                    last_d  = gnt_id;
                    rd_d    = 4'b0001 << gnt_id;
                    state_d = RD;
                end
            end
            RD: begin
                state_d = CAP;
            end
            CAP: begin
                if (head[DW-1:ADDR_WIDTH] != BROAD_TYPE_WIDTH'(BREQ_TYPE_NOP)) begin
                    addr_d  = head[ADDR_WIDTH-1:0];
                    type_d  = head[DW-1:ADDR_WIDTH];
                    cpu_d   = last_q;
                    id_d    = cnt_q;
                    wr_d    = 1'b1;
                    state_d = WR;
                end else begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WR: begin
                cnt_d   = cnt_q + BROAD_ID_WIDTH'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            cnt_q   <= '0;
            rd_q    <= 4'b0000;
            wr_q    <= 1'b0;
            drop_q  <= 1'b0;
            addr_q  <= '0;
            type_q  <= '0;
            cpu_q   <= 2'd0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            cpu_q   <= cpu_d;
            id_q    <= id_d;
        end
    end

    assign fifo_rd_array_o = rd_q;
    assign broad_fifo_wr_o = wr_q;
    assign drop_o          = drop_q;
    assign broad_addr_o    = addr_q;
    assign broad_type_o    = type_q;
    assign broad_cpu_id_o  = cpu_q;
    assign broad_id_o      = id_q;

endmodule

// File: tb/tb_mesi_isc_breq_rr_arb.sv
// tb/tb_mesi_isc_breq_rr_arb.sv - scoreboard bench for the breq round-robin drain controller
module tb_mesi_isc_breq_rr_arb;
    import mesi_isc_breq_arb_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             full = 1'b0;
    logic [3:0]       empty = 4'hF;
    logic [3:0][33:0] data_r = '0;
    logic [3:0]       rd;
    logic             wr, drop;
    logic [31:0]      addr;
    logic [1:0]       typ, cpu;
    logic [6:0]       id;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [1:0]  cpu;
        logic [6:0]  id;
        logic [1:0]  typ;
        logic [31:0] addr;
    } exp_t;

    breq_data_t fq[4][$];
    exp_t       exp_wr[$];
    int         exp_rd[$];
    int         exp_drop = 0;
    int         obs_cpu[$];
    int         obs_id[$];
    int         rd_cnt = 0, drop_cnt = 0, last_rd_cyc = 0, last_wr_cyc = 0;
    int         m_ptr = 3, m_cnt = 0;
    int         t0;

    mesi_isc_breq_rr_arb dut (
        .clk                (clk),
        .rst                (rst),
        .en_i               (en),
        .fifo_empty_array_i (empty),
        .fifo_data_array_i  (data_r),
        .broad_fifo_full_i  (full),
        .fifo_rd_array_o    (rd),
        .broad_fifo_wr_o    (wr),
        .broad_addr_o       (addr),
        .broad_type_o       (typ),
        .broad_cpu_id_o     (cpu),
        .broad_id_o         (id),
        .drop_o             (drop)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void upd_empty();
        for (int c = 0; c < 4; c++) empty[c] = (fq[c].size() == 0);
    endfunction

    task automatic push_entry(int c, logic [1:0] t, logic [31:0] a);
        breq_data_t e;
        e.typ  = t;
        e.addr = a;
        fq[c].push_back(e);
        upd_empty();
    endtask

    // Reference: repeatedly serve the first non-empty queue after the previous winner.
    task automatic model_drain();
        breq_data_t mq[4][$];
        breq_data_t e;
        exp_t       x;
        int         w, c;
        for (int i = 0; i < 4; i++) mq[i] = fq[i];
        while (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() > 0) begin
            w = -1;
            for (int k = 1; k <= 4; k++) begin
                c = (m_ptr + k) % 4;
                if (w < 0 && mq[c].size() > 0) w = c;
            end
            e = mq[w].pop_front();
            m_ptr = w;
            exp_rd.push_back(w);
            if (e.typ != 2'd0) begin
                x.cpu  = 2'(w);
                x.id   = 7'(m_cnt);
                x.typ  = e.typ;
                x.addr = e.addr;
                exp_wr.push_back(x);
                m_cnt = (m_cnt + 1) % 128;
            end else begin
                exp_drop++;
            end
        end
    endtask

    // Monitor and CPU queue model: a rd strobe pops the queue so data is valid in CAP.
    always @(negedge clk) begin
        int   w;
        exp_t x;
        if (!rst) begin
            chk("rd_onehot0", longint'($onehot0(rd)), 1);
            if (rd != 4'b0000) begin
                rd_cnt++;
                last_rd_cyc = cyc;
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected actual=%b expected=none", rd);
                end else begin
                    w = exp_rd.pop_front();
                    chk("rd_cpu", rd, 64'(1) << w);
                end
                for (int c = 0; c < 4; c++) begin
                    if (rd[c]) begin
                        chk("rd_nonempty", fq[c].size() > 0, 1);
                        if (fq[c].size() > 0) data_r[c] = fq[c].pop_front();
                    end
                end
                upd_empty();
            end
            if (wr) begin
                last_wr_cyc = cyc;
                chk("wr_not_full", full, 0);
                obs_cpu.push_back(int'(cpu));
                obs_id.push_back(int'(id));
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected actual=cpu%0d id%0d expected=none", cpu, id);
                end else begin
                    x = exp_wr.pop_front();
                    chk("wr_addr", addr, x.addr);
                    chk("wr_type", typ, x.typ);
                    chk("wr_cpu", cpu, x.cpu);
                    chk("wr_id", id, x.id);
                end
            end
            if (drop) begin
                drop_cnt++;
                chk("drop_expected", exp_drop > 0, 1);
                if (exp_drop > 0) exp_drop--;
            end
        end
    end

    task automatic wait_drain(int maxc, bit rand_en);
        bit done = 1'b0;
        for (int i = 0; i < maxc && !done; i++) begin
            @(negedge clk);
            if (rand_en) en = ($urandom_range(0, 3) != 0);
            done = (empty == 4'hF) && (exp_rd.size() == 0) && (exp_wr.size() == 0) && (exp_drop == 0);
        end
        chk("drain_done", done, 1);
        en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_model();
        for (int c = 0; c < 4; c++) fq[c].delete();
        upd_empty();
        exp_wr.delete(); exp_rd.delete(); obs_cpu.delete(); obs_id.delete();
        exp_drop = 0; rd_cnt = 0; drop_cnt = 0; m_ptr = 3; m_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_rd", rd, 0);
        chk("rst_wr", wr, 0);
        chk("rst_drop", drop, 0);
        chk("rst_addr", addr, 0);
        chk("rst_type", typ, 0);
        chk("rst_cpu", cpu, 0);
        chk("rst_id", id, 0);
        rst = 1'b0;

        // Single request from CPU2: rd one cycle after grant, write three cycles after.
        @(negedge clk);
        push_entry(2, 2'd1, 32'h1000);
        model_drain();
        en = 1'b1;
        t0 = cyc;
        wait_drain(50, 1'b0);
        chk("t1_rd_lat", last_rd_cyc - t0, 1);
        chk("t1_wr_lat", last_wr_cyc - t0, 3);
        chk("t1_writes", obs_id.size(), 1);
        if (obs_id.size() == 1) begin
            chk("t1_id", obs_id[0], 0);
            chk("t1_cpu", obs_cpu[0], 2);
        end

        // All four queues with two entries: strict rotation, ids 0..7.
        do_reset();
        en = 1'b0;
        for (int n = 0; n < 2; n++)
            for (int c = 0; c < 4; c++)
                push_entry(c, 2'($urandom_range(1, 3)), $urandom);
        model_drain();
        en = 1'b1;
        wait_drain(100, 1'b0);
        chk("t2_writes", obs_id.size(), 8);
        if (obs_id.size() == 8)
            for (int i = 0; i < 8; i++) begin
                chk("t2_cpu_order", obs_cpu[i], i % 4);
                chk("t2_id_order", obs_id[i], i);
            end

        // Broadcast FIFO full: nothing read until full drops, then rd one cycle later.
        do_reset();
        full = 1'b1;
        push_entry(1, 2'd2, 32'hCAFE0000);
        model_drain();
        en = 1'b1;
        repeat (10) @(negedge clk);
        chk("full_no_rd", rd_cnt, 0);
        t0 = cyc;
        full = 1'b0;
        wait_drain(50, 1'b0);
        chk("full_rd_lat", last_rd_cyc - t0, 1);

        // NOP head is dropped and does not consume a sequence id.
        do_reset();
        en = 1'b0;
        push_entry(0, 2'd0, 32'h0BAD0000);
        push_entry(0, 2'd3, 32'h00002000);
        model_drain();
        en = 1'b1;
        wait_drain(50, 1'b0);
        chk("nop_drops", drop_cnt, 1);
        chk("nop_writes", obs_id.size(), 1);
        if (obs_id.size() == 1) chk("nop_next_id", obs_id[0], 0);

        // 129 back-to-back writes: the id wraps 127 -> 0.
        do_reset();
        en = 1'b0;
        for (int i = 0; i < 129; i++) push_entry(i % 4, 2'($urandom_range(1, 3)), $urandom);
        model_drain();
        en = 1'b1;
        wait_drain(2000, 1'b0);
        chk("wrap_writes", obs_id.size(), 129);
        if (obs_id.size() == 129) begin
            chk("wrap_id127", obs_id[127], 127);
            chk("wrap_id128", obs_id[128], 0);
        end

        // Randomized batches with NOPs and en toggling mid-transaction.
        for (int r = 0; r < 8; r++) begin
            en = 1'b0;
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                int n = $urandom_range(0, 3);
                for (int j = 0; j < n; j++) push_entry(c, 2'($urandom_range(0, 3)), $urandom);
            end
            model_drain();
            wait_drain(1000, 1'b1);
        end

        // Reset during CAP: outputs clear at once, next grant goes to CPU0.
        en = 1'b0;
        @(negedge clk);
        push_entry(1, 2'd3, 32'hDEADBEEF);
        model_drain();
        en = 1'b1;
        for (int i = 0; i < 20 && rd == 4'b0000; i++) @(negedge clk);
        chk("t7_rd_seen", rd != 4'b0000, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t7_rst_rd", rd, 0);
        chk("t7_rst_wr", wr, 0);
        chk("t7_rst_drop", drop, 0);
        chk("t7_rst_addr", addr, 0);
        chk("t7_rst_type", typ, 0);
        chk("t7_rst_cpu", cpu, 0);
        chk("t7_rst_id", id, 0);
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        push_entry(2, 2'd1, 32'h00003000);
        push_entry(0, 2'd2, 32'h00004000);
        model_drain();
        wait_drain(100, 1'b0);
        chk("t7_writes", obs_cpu.size(), 2);
        if (obs_cpu.size() == 2) chk("t7_first_cpu", obs_cpu[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
